// File: rtl/jointer_sequencer_if.sv
// Bundle of signals between the jointer sequencer and its surroundings
// (job issuer, joint select line, matrix unit, result consumer).
// The slave modport is the sequencer's view; the master modport is the
// environment that issues jobs, answers mat_start and consumes the result.
`timescale 1ns/1ps

interface jointer_sequencer_if #(
    parameter int PASS_W = 4
);
    // job request side
    logic              start;
    logic [PASS_W-1:0] num_pass;
    logic              busy;
    // joint / buffer / matrix unit side
    logic              selector;
    logic              buf_rd;
    logic              mat_start;
    logic              mat_done;
    logic [PASS_W-1:0] pass_idx;
    // result handshake
    logic              res_valid;
    logic              res_ready;
    logic              err;

    modport slave (
        input  start,
        input  num_pass,
        input  mat_done,
        input  res_ready,
        output busy,
        output selector,
        output buf_rd,
        output mat_start,
        output pass_idx,
        output res_valid,
        output err
    );

    modport master (
        output start,
        output num_pass,
        output mat_done,
        output res_ready,
        input  busy,
        input  selector,
        input  buf_rd,
        input  mat_start,
        input  pass_idx,
        input  res_valid,
        input  err
    );
endinterface

// File: rtl/jointer_sequencer.sv
// jointer_sequencer: runs a job of N matrix passes through the
// matrix-unit / buffer joint. Pass 0 reads operands from the buffer
// (selector=1), later passes feed the matrix output back (selector=0).
// Each pass pulses mat_start and waits for mat_done; the final result is
// offered with a res_valid/res_ready handshake. num_pass=0 passes the
// buffer straight through to the result without touching the matrix unit.
//
// Optional feature: define JOINTER_TIMEOUT_EN to add a WAIT watchdog of
// TMO_W bits that aborts the job and raises a sticky err flag. Without the
// macro WAIT holds indefinitely and err is tied low.
`timescale 1ns/1ps

module jointer_sequencer #(
    parameter int PASS_W = 4,
    parameter int TMO_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jointer_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic              selector_reg;
    logic              buf_rd_reg;
    logic              mat_start_reg;
    logic              res_valid_reg;
    logic [PASS_W-1:0] pass_idx_reg;
    logic [PASS_W-1:0] num_pass_reg;

    // the pass currently in flight is the last one of the job
    logic              last_pass;
    assign last_pass = (pass_idx_reg == (num_pass_reg - PASS_W'(1)));

`ifdef JOINTER_TIMEOUT_EN
    // Abort on the WAIT cycle whose increment would bring the count to
    // 2^TMO_W-1, i.e. after 2^TMO_W-1 WAIT cycles without mat_done.
    localparam logic [TMO_W-1:0] TMO_ABORT_AT = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic              err_reg;
    logic              tmo_expire;
    assign tmo_expire = (tmo_cnt_reg == TMO_ABORT_AT);
`endif

    // sequencer FSM: all outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            selector_reg  <= 1'b1;
            buf_rd_reg    <= 1'b0;
            mat_start_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            pass_idx_reg  <= '0;
            num_pass_reg  <= '0;
`ifdef JOINTER_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            // single-cycle strobes fall back low unless re-armed below
            buf_rd_reg    <= 1'b0;
            mat_start_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        num_pass_reg <= bus.num_pass;
                        busy_reg     <= 1'b1;
                        selector_reg <= 1'b1;
                        buf_rd_reg   <= 1'b1;
                        pass_idx_reg <= '0;
`ifdef JOINTER_TIMEOUT_EN
                        err_reg      <= 1'b0;
`endif
                        if (bus.num_pass == '0) begin
                            // zero passes: buffer data is the result
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= ISSUE;
                            mat_start_reg <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    // mat_done is not looked at here; the pass has only
                    // just been started
                    state_reg <= WAIT;
`ifdef JOINTER_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                end

                WAIT: begin
                    if (bus.mat_done) begin
                        selector_reg <= 1'b0;
                        if (last_pass) begin
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= ISSUE;
                            mat_start_reg <= 1'b1;
                            pass_idx_reg  <= pass_idx_reg + PASS_W'(1);
                        end
                    end
`ifdef JOINTER_TIMEOUT_EN
                    else if (tmo_expire) begin
                        // matrix unit never answered: drop the job
                        state_reg     <= IDLE;
                        err_reg       <= 1'b1;
                        busy_reg      <= 1'b0;
                        res_valid_reg <= 1'b0;
                        selector_reg  <= 1'b1;
                        pass_idx_reg  <= '0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
`endif
                end

                DONE: begin
                    // selector keeps pointing at the result source until
                    // the consumer takes it
                    if (bus.res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        pass_idx_reg  <= '0;
                        selector_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.selector  = selector_reg;
    assign bus.buf_rd    = buf_rd_reg;
    assign bus.mat_start = mat_start_reg;
    assign bus.pass_idx  = pass_idx_reg;
    assign bus.res_valid = res_valid_reg;

`ifdef JOINTER_TIMEOUT_EN
    assign bus.err = err_reg;
`else
    // no watchdog in this build, so nothing can raise an error
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_jointer_sequencer.sv
// Directed bench for jointer_sequencer. A small matrix-unit model answers
// each mat_start with mat_done a programmable number of cycles later.
// Expected per-pass records and per-job result records are queued when a
// job is issued and popped when the DUT pulses mat_start / raises res_valid.
`timescale 1ns/1ps

module tb_jointer_sequencer;

    localparam int PASS_W = 4;
    localparam int TMO_W  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    jointer_sequencer_if #(.PASS_W(PASS_W)) bus ();

    jointer_sequencer #(
        .PASS_W (PASS_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic              sel;
        logic              buf_rd;
        logic [PASS_W-1:0] idx;
    } pass_exp_t;

    typedef struct {
        logic sel;
        logic buf_rd;
        int   lat;
    } res_exp_t;

    pass_exp_t pass_q[$];
    res_exp_t  res_q[$];

    int   errors         = 0;
    int   checks         = 0;
    int   cyc            = 0;
    int   start_cyc      = 0;
    int   done_delay     = 0;   // 0: matrix unit never answers
    int   done_pend      = 0;
    int   mat_start_cnt  = 0;
    int   buf_rd_cnt     = 0;
    logic last_sel       = 1'b1;
    logic prev_res_valid = 1'b0;

    // idle output vector: {busy, selector, buf_rd, mat_start, pass_idx, res_valid, err}
    localparam logic [31:0] IDLE_OUTS     = 32'h0000_0100;
    localparam logic [31:0] IDLE_ERR_OUTS = 32'h0000_0101;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, bus.busy, bus.selector, bus.buf_rd, bus.mat_start,
                bus.pass_idx, bus.res_valid, bus.err};
    endfunction

    // one clock: advance, then sample outputs and run the matrix-unit model
    task automatic tick();
        pass_exp_t e;
        res_exp_t  r;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.mat_done = 1'b0;
        if (done_pend > 0) begin
            done_pend--;
            if (done_pend == 0) bus.mat_done = 1'b1;
        end
        if (bus.mat_start === 1'b1) begin
            mat_start_cnt++;
            last_sel = bus.selector;
            if (done_delay > 0) done_pend = done_delay;
            if (pass_q.size() == 0) begin
                check("mat_start_unexpected", 32'd1, 32'd0);
            end else begin
                e = pass_q.pop_front();
                check("pass_selector", bus.selector, e.sel);
                check("pass_buf_rd", bus.buf_rd, e.buf_rd);
                check("pass_idx", bus.pass_idx, e.idx);
            end
        end else if (bus.busy === 1'b1 && bus.res_valid === 1'b0) begin
            check("wait_selector_hold", bus.selector, last_sel);
            check("wait_no_buf_rd", bus.buf_rd, 1'b0);
        end
        if (bus.buf_rd === 1'b1) buf_rd_cnt++;
        if (bus.res_valid === 1'b1 && prev_res_valid === 1'b0) begin
            if (res_q.size() == 0) begin
                check("res_unexpected", 32'd1, 32'd0);
            end else begin
                r = res_q.pop_front();
                check("res_latency", cyc - start_cyc, r.lat);
                check("res_selector", bus.selector, r.sel);
                check("res_buf_rd", bus.buf_rd, r.buf_rd);
            end
        end
        prev_res_valid = bus.res_valid;
    endtask

    // full job: issue, let the model answer after d cycles, hold ready low
    // for ready_wait cycles, then take the result. poke pulses start during
    // WAIT and together with the result handshake.
    task automatic run_job(input int n, input int d, input int ready_wait, input bit poke);
        pass_exp_t e;
        res_exp_t  r;
        int        k;
        int        ms0;
        int        br0;
        ms0 = mat_start_cnt;
        br0 = buf_rd_cnt;
        for (int i = 0; i < n; i++) begin
            e.sel    = (i == 0);
            e.buf_rd = (i == 0);
            e.idx    = PASS_W'(i);
            pass_q.push_back(e);
        end
        r.sel    = (n == 0);
        r.buf_rd = (n == 0);
        r.lat    = n * (d + 1) + 1;
        res_q.push_back(r);

        bus.num_pass = PASS_W'(n);
        bus.start    = 1'b1;
        done_delay   = d;
        start_cyc    = cyc;
        tick();
        bus.start    = 1'b0;
        bus.num_pass = PASS_W'($urandom_range(0, 15));
        check("start_accept_busy", bus.busy, 1'b1);
        check("start_clears_err", bus.err, 1'b0);

        k = 0;
        while (bus.res_valid !== 1'b1 && k < 2000) begin
            if (poke) bus.start = (k == 1);
            tick();
            k++;
        end
        bus.start = 1'b0;
        check("res_valid_arrives", bus.res_valid, 1'b1);

        for (int i = 0; i < ready_wait; i++) begin
            tick();
            check("done_hold_valid", bus.res_valid, 1'b1);
            check("done_hold_selector", bus.selector, (n == 0));
            check("done_hold_busy", bus.busy, 1'b1);
        end

        bus.res_ready = 1'b1;
        if (poke) begin
            bus.start    = 1'b1;
            bus.num_pass = 4'd3;
        end
        tick();
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check("handshake_idle", outs(), IDLE_OUTS);
        tick();
        check("no_queued_start", outs(), IDLE_OUTS);
        check("mat_start_count", mat_start_cnt - ms0, n);
        check("buf_rd_count", buf_rd_cnt - br0, 1);
        check("pass_q_drained", pass_q.size(), 0);
    endtask

    initial begin
        pass_exp_t e;
        int        k;
        int        waits;

        bus.start     = 1'b0;
        bus.num_pass  = '0;
        bus.mat_done  = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        check("reset_outputs", outs(), IDLE_OUTS);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_after_reset", outs(), IDLE_OUTS);
        end
        check("idle_no_pulses", mat_start_cnt + buf_rd_cnt, 0);

        run_job(3, 4, 2, 1'b0);   // test-plan job: done 4 cycles after each start
        run_job(0, 1, 0, 1'b0);   // buffer pass-through
        run_job(1, 1, 0, 1'b0);   // zero-wait, 2N+1 = 3
        run_job(2, 1, 1, 1'b0);   // zero-wait, 2N+1 = 5
        run_job(2, 4, 10, 1'b1);  // ignored starts, ready held low 10 cycles
        run_job(15, 1, 0, 1'b0);  // largest job, final pass_idx 14

        // reset in the WAIT of pass 1 of a 3-pass job
        e.sel = 1'b1; e.buf_rd = 1'b1; e.idx = 4'd0; pass_q.push_back(e);
        e.sel = 1'b0; e.buf_rd = 1'b0; e.idx = 4'd1; pass_q.push_back(e);
        bus.num_pass = 4'd3;
        bus.start    = 1'b1;
        done_delay   = 3;
        start_cyc    = cyc;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (!(bus.pass_idx == 4'd1 && bus.mat_start === 1'b0 && bus.busy === 1'b1) && k < 100) begin
            tick();
            k++;
        end
        check("reach_pass1_wait", {bus.busy, bus.pass_idx}, 5'h11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), IDLE_OUTS);
        done_pend    = 0;
        done_delay   = 0;
        bus.mat_done = 1'b0;
        tick();
        check("reset_held_outputs", outs(), IDLE_OUTS);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_idle", outs(), IDLE_OUTS);
        check("reset_job_lost", pass_q.size(), 0);
        run_job(1, 2, 0, 1'b0);

`ifdef JOINTER_TIMEOUT_EN
        // matrix unit never answers: abort after 15 WAIT cycles
        e.sel = 1'b1; e.buf_rd = 1'b1; e.idx = 4'd0; pass_q.push_back(e);
        bus.num_pass = 4'd2;
        bus.start    = 1'b1;
        done_delay   = 0;
        start_cyc    = cyc;
        tick();
        bus.start = 1'b0;
        k     = 0;
        waits = 0;
        while (bus.busy === 1'b1 && k < 100) begin
            tick();
            k++;
            if (bus.busy === 1'b1 && bus.mat_start === 1'b0) waits++;
        end
        check("timeout_wait_cycles", waits, 15);
        check("timeout_abort_outputs", outs(), IDLE_ERR_OUTS);
        check("timeout_pass_q", pass_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_sticky", outs(), IDLE_ERR_OUTS);
        end
        // done on the terminal-count cycle wins over the watchdog
        run_job(1, 15, 0, 1'b0);
        check("terminal_done_no_err", bus.err, 1'b0);
`else
        // without the watchdog a long wait still completes normally
        run_job(1, 40, 0, 1'b0);
        check("no_watchdog_err", bus.err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/jointer_sequencer.md
# jointer_sequencer

Sequencer for the matrix-unit / buffer joint. It accepts a job of N matrix passes and drives the joint's `selector`: pass 0 takes operands from the buffer, passes 1..N-1 feed the matrix output back. It pulses the matrix unit's start and waits for its done for every pass, then presents the final result with a valid/ready handshake. It sits between the job issuer and the joint/matrix-unit pair, owning the joint's select line.

## Interface
- `PASS_W`, 4: width of pass count and pass index.
- `TMO_W`, 8: watchdog counter width; used only with `JOINTER_TIMEOUT_EN`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `num_pass`  in  PASS_W  matrix passes for the job; latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `selector`  out  1  joint select: 1 = buffer, 0 = matrix output.
- `buf_rd`  out  1  one-cycle buffer read pulse.
- `mat_start`  out  1  one-cycle matrix-unit start pulse.
- `mat_done`  in  1  matrix unit finished the current pass; one-cycle pulse.
- `pass_idx`  out  PASS_W  index of the current pass.
- `res_valid`  out  1  joint output holds the final result.
- `res_ready`  in  1  consumer accepts the result.
- `err`  out  1  watchdog abort flag; constant 0 without `JOINTER_TIMEOUT_EN`.

## Operation
- All outputs are registered. Reset values: `busy`=0, `selector`=1, `buf_rd`=0, `mat_start`=0, `pass_idx`=0, `res_valid`=0, `err`=0, state IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE + `start`: latch `num_pass`, clear `err`.
  - If `num_pass`=0, go to ISSUE0. ISSUE0 is a DONE entry with `buf_rd`=1 and `selector`=1, so the buffer passes straight through.
  - Otherwise go to ISSUE.
- ISSUE: `mat_start`=1 for one cycle. On pass 0, `buf_rd`=1 and `selector`=1; on later passes `selector`=0. Next state is WAIT unconditionally. `mat_done` is ignored in ISSUE.
- WAIT, no `mat_done`: hold.
- WAIT + `mat_done` with `pass_idx` < latched N-1: increment `pass_idx`, set `selector`=0, go to ISSUE.
- WAIT + `mat_done` with `pass_idx` = N-1: go to DONE with `selector`=0.
- DONE: `res_valid`=1, and `selector` is held. `res_valid` & `res_ready` returns to IDLE: `res_valid`=0, `busy`=0, `pass_idx`=0, `selector`=1.
- `start` outside IDLE is ignored and not queued, including `start` coincident with the DONE handshake.
- `num_pass` changes after acceptance have no effect.
- `pass_idx` never wraps. The maximum N = 2^PASS_W-1 gives a final index of 2^PASS_W-2.
- Reset mid-job: outputs take reset values immediately. No pulse is emitted, and the job is lost.

## Timing
- `start` accepted at edge t:
  - ISSUE visible from t+1, with `mat_start` and `buf_rd` high for exactly that cycle.
  - WAIT from t+2.
- `mat_done` sampled at edge d (in WAIT), more passes remaining: next ISSUE at d+1 with `mat_start` high, `pass_idx` incremented.
- `mat_done` sampled at edge d on the last pass: `res_valid` high from d+1.
- Minimum pass period is 2 cycles (ISSUE + one WAIT cycle).
- N passes with zero-wait done (mat_done in the first WAIT cycle): `res_valid` rises 2N+1 cycles after the `start` edge.
- `num_pass`=0: `res_valid` rises 1 cycle after `start`, with `buf_rd` high in that same cycle.
- `selector` is stable from each ISSUE through the end of that pass's WAIT.

## Configuration
- `JOINTER_TIMEOUT_EN` defined:
  - A TMO_W-bit counter clears on entry to WAIT and increments on each WAIT cycle without `mat_done`.
  - When the count reaches 2^TMO_W-1, go to IDLE: `err`=1, `busy`=0, `res_valid`=0, `selector`=1, `pass_idx`=0.
  - `err` is sticky until the next accepted `start`.
  - `mat_done` in the same cycle as terminal count wins: normal transition, no error.
- `JOINTER_TIMEOUT_EN` undefined: no counter; WAIT holds indefinitely; `err` tied 0.

## Test plan
- Reset release, idle 5 cycles -> `selector`=1, all other outputs 0, no pulses.
- `num_pass`=3, `mat_done` 4 cycles after each `mat_start`:
  - 3 `mat_start` pulses, `buf_rd` only on the first.
  - `selector` 1/0/0 per pass, `pass_idx` 0,1,2.
  - `res_valid` high until `res_ready`, then IDLE.
- `num_pass`=0 -> `res_valid` one cycle after `start`, `buf_rd`=1, `selector`=1, zero `mat_start` pulses.
- `start` pulsed during WAIT and during the DONE handshake cycle -> ignored. `res_ready` held low 10 cycles in DONE -> `res_valid` and `selector`=0 held.
- `rst_n` asserted mid-WAIT of pass 1 of 3 -> all outputs at reset values immediately. A new `start` with `num_pass`=1 completes normally.
- With `JOINTER_TIMEOUT_EN`, `TMO_W`=4, `mat_done` never asserted -> abort after 15 WAIT cycles, `err`=1, `busy`=0. The next `start` clears `err`.
